// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window sequencer.
package sobel_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_PRESENT,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int WIN_SLOTS = 9;

    // Number of interior 3x3 windows in a w x h image.
    function automatic int win_count(input int w, input int h);
        return (w - 2) * (h - 2);
    endfunction

endpackage

// File: rtl/sobel_wr_delay.sv
// Fixed-latency {valid,addr} delay line matching the convolution engine.
// o_empty_next is high when nothing will be left in the line after this cycle
// (only the output stage may be occupied, and nothing is being pushed).
module sobel_wr_delay #(
    parameter int DEPTH  = 3,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_empty_next
);

    logic [DEPTH-1:0]             r_vld;
    logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
    logic                         w_pending;

    // Shift every cycle; the engine has no backpressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld  <= '0;
            r_addr <= '0;
        end else begin
            r_vld[0]  <= i_push;
            r_addr[0] <= i_addr;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_addr[i] <= r_addr[i-1];
            end
        end
    end

    // Any entry that will still be in flight next cycle.
    always_comb begin
        w_pending = i_push;
        for (int i = 0; i < DEPTH - 1; i++) w_pending = w_pending | r_vld[i];
    end

    assign o_valid      = r_vld[DEPTH-1];
    assign o_addr       = r_addr[DEPTH-1];
    assign o_empty_next = ~w_pending;

endmodule

// File: rtl/sobel_window_sequencer.sv
// Walks every interior pixel, fetches its 3x3 neighbourhood from the pixel RAM,
// hands it to the convolution engine and issues the matching result write.
module sobel_window_sequencer
    import sobel_pkg::*;
#(
    parameter int IMG_W     = 16,
    parameter int IMG_H     = 16,
    parameter int ADDR_W    = 8,
    parameter int data_size = 24,
    parameter int CONV_LAT  = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           rd_en,
    output logic [ADDR_W-1:0]              rd_addr,
    input  logic [data_size-1:0]           rd_data,
    output logic                           win_valid,
    input  logic                           win_ready,
    output logic [WIN_SLOTS*data_size-1:0] win_data,
    output logic                           wr_en,
    output logic [ADDR_W-1:0]              wr_addr
);

    localparam int XW      = $clog2(IMG_W);
    localparam int YW      = $clog2(IMG_H);
    localparam int NUM_WIN = win_count(IMG_W, IMG_H);
    localparam int CW      = $clog2(NUM_WIN + 1);

    if (IMG_W < 3 || IMG_H < 3 || CONV_LAT < 1 || ADDR_W < $clog2(IMG_W * IMG_H)) begin : g_bad_param
        $error("sobel_window_sequencer: illegal parameter set");
    end

    state_t                                r_state;
    logic [XW-1:0]                         r_x;
    logic [YW-1:0]                         r_y;
    logic [1:0]                            r_row, r_col;
    logic [CW-1:0]                         r_win_idx;
    logic                                  r_busy, r_done, r_rd_en, r_win_valid;
    logic [ADDR_W-1:0]                     r_rd_addr;
    logic                                  r_cap_vld;
    logic [3:0]                            r_cap_slot;
    logic [WIN_SLOTS-1:0][data_size-1:0]   r_win;

    logic              w_accept, w_last_win, w_last_x, w_last_slot, w_empty_next;
    logic [XW-1:0]     w_nx;
    logic [YW-1:0]     w_ny;
    logic [1:0]        w_nrow, w_ncol;
    logic [ADDR_W-1:0] w_centre;

    // Neighbour address for centre (x,y), row/col offset 0..2 from the top-left.
    function automatic logic [ADDR_W-1:0] f_addr(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                                 input logic [1:0] row, input logic [1:0] col);
        return (ADDR_W'(y) + ADDR_W'(row) - ADDR_W'(1)) * ADDR_W'(IMG_W)
             + ADDR_W'(x) + ADDR_W'(col) - ADDR_W'(1);
    endfunction

    assign w_accept    = r_win_valid & win_ready;
    assign w_last_win  = (r_win_idx == CW'(NUM_WIN - 1));
    assign w_last_x    = (r_x == XW'(IMG_W - 2));
    assign w_nx        = w_last_x ? XW'(1) : r_x + XW'(1);
    assign w_ny        = w_last_x ? r_y + YW'(1) : r_y;
    assign w_last_slot = (r_row == 2'd2) && (r_col == 2'd2);
    assign w_ncol      = (r_col == 2'd2) ? 2'd0 : r_col + 2'd1;
    assign w_nrow      = (r_col == 2'd2) ? r_row + 2'd1 : r_row;
    assign w_centre    = ADDR_W'(r_y) * ADDR_W'(IMG_W) + ADDR_W'(r_x);

    // Frame FSM; every output it drives is registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_win_idx   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_win_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_state   <= S_FETCH;
                    r_busy    <= 1'b1;
                    r_x       <= XW'(1);
                    r_y       <= YW'(1);
                    r_row     <= '0;
                    r_col     <= '0;
                    r_win_idx <= '0;
                    r_rd_en   <= 1'b1;
                    r_rd_addr <= f_addr(XW'(1), YW'(1), 2'd0, 2'd0);
                end
                S_FETCH: if (w_last_slot) begin
                    r_state <= S_CAPTURE;
                    r_rd_en <= 1'b0;
                end else begin
                    r_row     <= w_nrow;
                    r_col     <= w_ncol;
                    r_rd_addr <= f_addr(r_x, r_y, w_nrow, w_ncol);
                end
                S_CAPTURE: begin
                    r_state     <= S_PRESENT;
                    r_win_valid <= 1'b1;
                end
                S_PRESENT: if (win_ready) begin
                    r_win_valid <= 1'b0;
                    if (w_last_win) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_state   <= S_FETCH;
                        r_x       <= w_nx;
                        r_y       <= w_ny;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_win_idx <= r_win_idx + CW'(1);
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= f_addr(w_nx, w_ny, 2'd0, 2'd0);
                    end
                end
                S_DRAIN: if (w_empty_next) begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Capture RAM data one cycle after each read into its window slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cap_vld  <= 1'b0;
            r_cap_slot <= '0;
            r_win      <= '0;
        end else begin
            r_cap_vld  <= r_rd_en;
            r_cap_slot <= 4'({r_row, 1'b0}) + 4'(r_row) + 4'(r_col);
            if (r_cap_vld) r_win[r_cap_slot] <= rd_data;
        end
    end

    sobel_wr_delay #(
        .DEPTH  (CONV_LAT),
        .ADDR_W (ADDR_W)
    ) u_wr_delay (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_accept),
        .i_addr       (w_centre),
        .o_valid      (wr_en),
        .o_addr       (wr_addr),
        .o_empty_next (w_empty_next)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign rd_en     = r_rd_en;
    assign rd_addr   = r_rd_addr;
    assign win_valid = r_win_valid;
    assign win_data  = r_win;

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Scoreboard bench: a 4x4/latency-3 instance for the main scenarios and a
// 5x3/latency-1 instance for the narrow-image, short-latency case.
module tb_sobel_window_sequencer;

    localparam int DW = 24;
    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0, failures = 0;

    // ---------------- instance A: 4x4, CONV_LAT=3 ----------------
    logic            rst_n, start, win_ready, busy, done, rd_en, win_valid, wr_en;
    logic [AW-1:0]   rd_addr, wr_addr;
    logic [DW-1:0]   rd_data;
    logic [9*DW-1:0] win_data;

    sobel_window_sequencer #(.IMG_W(4), .IMG_H(4), .ADDR_W(AW), .data_size(DW), .CONV_LAT(3)) dut (
        .clk(clk), .reset(rst_n), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .wr_en(wr_en), .wr_addr(wr_addr));

    always @(posedge clk) if (rd_en) rd_data <= DW'(rd_addr);

    // ---------------- instance B: 5x3, CONV_LAT=1 ----------------
    logic            rst_b, start_b, busy_b, done_b, rd_en_b, win_valid_b, wr_en_b;
    logic [AW-1:0]   rd_addr_b, wr_addr_b;
    logic [DW-1:0]   rd_data_b;
    logic [9*DW-1:0] win_data_b;

    sobel_window_sequencer #(.IMG_W(5), .IMG_H(3), .ADDR_W(AW), .data_size(DW), .CONV_LAT(1)) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .win_valid(win_valid_b), .win_ready(1'b1), .win_data(win_data_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b));

    always @(posedge clk) if (rd_en_b) rd_data_b <= DW'(rd_addr_b);

    // ---------------- scoreboard ----------------
    int              exp_rd[$];
    logic [9*DW-1:0] exp_win[$];
    int              exp_wr[$];
    int              hs_cyc[$];
    int              exp_wr_b[$];
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
    int wr_cnt_b = 0, done_cnt_b = 0, last_wr_b = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s", nm);
    endtask

    task automatic clear_sb();
        exp_rd.delete(); exp_win.delete(); exp_wr.delete(); hs_cyc.delete();
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    endtask

    // Hand-derived 4x4 frame: centres (1,1),(2,1),(1,2),(2,2).
    task automatic push_frame_a();
        logic [9*DW-1:0] w;
        int a;
        for (int y = 1; y <= 2; y++)
            for (int x = 1; x <= 2; x++) begin
                w = '0;
                for (int k = 0; k < 9; k++) begin
                    a = (y - 1 + k / 3) * 4 + (x - 1 + k % 3);
                    exp_rd.push_back(a);
                    w[k*DW +: DW] = DW'(a);
                end
                exp_win.push_back(w);
                exp_wr.push_back(y * 4 + x);
            end
    endtask

    // Monitor A.
    always @(negedge clk) if (rst_n) begin
        if (rd_en) begin
            rd_cnt++;
            if (exp_rd.size() == 0) fail("rd_extra");
            else chk("rd_addr", rd_addr, exp_rd.pop_front());
        end
        if (rd_en && win_valid) fail("rd_en_with_win_valid");
        if (win_valid && win_ready) begin
            if (exp_win.size() == 0) fail("win_extra");
            else chk("win_data", win_data, exp_win.pop_front());
            hs_cyc.push_back(cyc);
        end
        if (wr_en) begin
            wr_cnt++;
            if (exp_wr.size() == 0 || hs_cyc.size() == 0) fail("wr_extra");
            else begin
                chk("wr_addr", wr_addr, exp_wr.pop_front());
                chk("wr_latency", cyc - hs_cyc.pop_front(), 3);
            end
        end
        if (done) begin
            done_cnt++;
            chk("busy_at_done", busy, 1'b0);
        end
    end

    // Monitor B.
    always @(negedge clk) if (rst_b) begin
        if (wr_en_b) begin
            wr_cnt_b++;
            last_wr_b = cyc;
            if (exp_wr_b.size() == 0) fail("b_wr_extra");
            else chk("b_wr_addr", wr_addr_b, exp_wr_b.pop_front());
        end
        if (done_b) begin
            done_cnt_b++;
            chk("b_done_after_last_wr", cyc - last_wr_b, 1);
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic finish_frame_a(input string nm);
        int n = 0;
        while (done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) fail({nm, "_done_timeout"});
        repeat (4) @(negedge clk);
        chk({nm, "_done_count"}, done_cnt, 1);
        chk({nm, "_wr_count"}, wr_cnt, 4);
        chk({nm, "_busy_after"}, busy, 1'b0);
        chk({nm, "_rd_left"}, exp_rd.size(), 0);
        chk({nm, "_wr_left"}, exp_wr.size(), 0);
    endtask

    initial begin
        logic [9*DW-1:0] snap;
        int n;
        rst_n = 1'b0; start = 1'b0; win_ready = 1'b1;
        rst_b = 1'b0; start_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_win_valid", win_valid, 1'b0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_win_data", win_data, '0);
        rst_n = 1'b1;

        // 1/2: plain frame, ready always high.
        clear_sb(); push_frame_a();
        pulse_start();
        #1 chk("busy_after_start", busy, 1'b1);
        finish_frame_a("t1");

        // 3: stall the first window for several cycles.
        clear_sb(); push_frame_a();
        win_ready = 1'b0;
        pulse_start();
        n = 0;
        while (win_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) fail("t3_valid_timeout");
        snap = win_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_valid_held", win_valid, 1'b1);
            chk("t3_data_stable", win_data, snap);
            chk("t3_no_rd", rd_en, 1'b0);
        end
        @(posedge clk); #1 win_ready = 1'b1;
        finish_frame_a("t3");

        // 4: start while busy is ignored.
        clear_sb(); push_frame_a();
        pulse_start();
        repeat (20) @(posedge clk);
        pulse_start();
        finish_frame_a("t4");

        // 5: reset during the second window's fetch, then a clean frame.
        clear_sb(); push_frame_a();
        pulse_start();
        n = 0;
        while (rd_cnt < 11 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) fail("t5_fetch_timeout");
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 1'b0);
        chk("t5_rd_en", rd_en, 1'b0);
        chk("t5_rd_addr", rd_addr, '0);
        chk("t5_win_valid", win_valid, 1'b0);
        chk("t5_wr_en", wr_en, 1'b0);
        chk("t5_win_data", win_data, '0);
        repeat (3) @(posedge clk);
        chk("t5_no_done", done_cnt, 0);
        #1 rst_n = 1'b1;
        clear_sb(); push_frame_a();
        pulse_start();
        finish_frame_a("t5");

        // 6: 5x3 image, CONV_LAT=1.
        exp_wr_b.push_back(6); exp_wr_b.push_back(7); exp_wr_b.push_back(8);
        @(posedge clk); #1 rst_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        n = 0;
        while (done_b !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) fail("t6_done_timeout");
        repeat (3) @(negedge clk);
        chk("t6_wr_count", wr_cnt_b, 3);
        chk("t6_done_count", done_cnt_b, 1);
        chk("t6_busy_after", busy_b, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
